// File: rtl/krnl_acc_pkg.sv
// Shared constants for the kernel accelerator control path: FSM encodings
// and default burst geometry used by the ap_ctrl_chain sequencer.
package krnl_acc_pkg;

  localparam int DEF_BYTES_PER_WORD = 16;
  localparam int DEF_MAX_BURST      = 64;
  localparam int DEF_LEN_W          = 9;
  localparam int OUTST_W            = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/krnl_acc_burst_gen.sv
// Splits a word count into MAX_BURST-sized commands on a valid/ready channel;
// the final command carries the remainder.
module krnl_acc_burst_gen
  import krnl_acc_pkg::*;
#(
  parameter int BPW  = DEF_BYTES_PER_WORD,
  parameter int MAXB = DEF_MAX_BURST,
  parameter int LW   = DEF_LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [63:0]   base,
  input  logic [31:0]   words,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [63:0]   cmd_addr,
  output logic [LW-1:0] cmd_len,
  output logic          empty
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAXB);

  logic [31:0] left_q, left_d;
  logic [63:0] addr_q, addr_d;
  logic        hs;

  assign empty     = (left_q == '0);
  assign cmd_valid = !empty;
  assign cmd_addr  = addr_q;
  assign cmd_len   = (left_q >= 32'(MAXB)) ? MAX_LEN : left_q[LW-1:0];
  assign hs        = cmd_valid && cmd_ready;

  // Registers only move on a handshake, so a stalled command stays stable.
  always_comb begin
    left_d = left_q;
    addr_d = addr_q;
    if (load) begin
      left_d = words;
      addr_d = base;
    end else if (hs) begin
      left_d = left_q - 32'(cmd_len);
      addr_d = addr_q + (64'(cmd_len) * 64'(BPW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
      addr_q <= '0;
    end else begin
      left_q <= left_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/krnl_acc_ap_sequencer.sv
// ap_ctrl_chain sequencer: latches job arguments, drives read/write burst
// command generators and tracks outstanding write bursts until the job drains.
module krnl_acc_ap_sequencer
  import krnl_acc_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int MAX_BURST      = DEF_MAX_BURST,
  parameter int LEN_W          = DEF_LEN_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ap_start,
  input  logic             ap_continue,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dest_addr,
  input  logic [31:0]      words_num,
  input  logic             mode,
  input  logic             cbc_mode,
  input  logic [31:0]      iv_w3,
  input  logic [31:0]      iv_w2,
  input  logic [31:0]      iv_w1,
  input  logic [31:0]      iv_w0,
  output logic             core_start,
  output logic             core_mode,
  output logic             core_cbc_mode,
  output logic [127:0]     core_iv,
  output logic             rd_cmd_valid,
  input  logic             rd_cmd_ready,
  output logic [63:0]      rd_cmd_addr,
  output logic [LEN_W-1:0] rd_cmd_len,
  output logic             wr_cmd_valid,
  input  logic             wr_cmd_ready,
  output logic [63:0]      wr_cmd_addr,
  output logic [LEN_W-1:0] wr_cmd_len,
  input  logic             wr_burst_done
);

  logic [1:0]         state_q, state_d;
  logic               start_q;
  logic [63:0]        src_q, dest_q;
  logic [31:0]        words_q;
  logic               mode_q, cbc_q;
  logic [127:0]       iv_q;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               take, wr_hs, rd_empty, wr_empty;

  assign take          = (state_q == S_IDLE) && ap_start;
  assign wr_hs         = wr_cmd_valid && wr_cmd_ready;
  assign ap_idle       = (state_q == S_IDLE);
  assign ap_done       = (state_q == S_DONE);
  assign ap_ready      = start_q;
  assign core_start    = start_q;
  assign core_mode     = mode_q;
  assign core_cbc_mode = cbc_q;
  assign core_iv       = iv_q;

  // Generators load from the latched arguments one cycle after acceptance,
  // so ISSUE must not read their empty flags during that load cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = (words_num == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (!start_q && rd_empty && wr_empty) state_d = S_DRAIN;
      S_DRAIN: if (outst_q == '0) state_d = S_DONE;
      S_DONE:  if (ap_continue) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (take) outst_d = '0;
    else if (wr_hs && !wr_burst_done) outst_d = outst_q + 1'b1;
    else if (!wr_hs && wr_burst_done && (outst_q != '0)) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      src_q   <= '0;
      dest_q  <= '0;
      words_q <= '0;
      mode_q  <= 1'b0;
      cbc_q   <= 1'b0;
      iv_q    <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= take;
      outst_q <= outst_d;
      if (take) begin
        src_q   <= src_addr;
        dest_q  <= dest_addr;
        words_q <= words_num;
        mode_q  <= mode;
        cbc_q   <= cbc_mode;
        iv_q    <= {iv_w3, iv_w2, iv_w1, iv_w0};
      end
    end
  end

  krnl_acc_burst_gen #(.BPW(BYTES_PER_WORD), .MAXB(MAX_BURST), .LW(LEN_W)) u_rd_gen (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (start_q),
    .base      (src_q),
    .words     (words_q),
    .cmd_valid (rd_cmd_valid),
    .cmd_ready (rd_cmd_ready),
    .cmd_addr  (rd_cmd_addr),
    .cmd_len   (rd_cmd_len),
    .empty     (rd_empty)
  );

  krnl_acc_burst_gen #(.BPW(BYTES_PER_WORD), .MAXB(MAX_BURST), .LW(LEN_W)) u_wr_gen (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (start_q),
    .base      (dest_q),
    .words     (words_q),
    .cmd_valid (wr_cmd_valid),
    .cmd_ready (wr_cmd_ready),
    .cmd_addr  (wr_cmd_addr),
    .cmd_len   (wr_cmd_len),
    .empty     (wr_empty)
  );

endmodule

// File: tb/tb_krnl_acc_ap_sequencer.sv
// Directed bench for krnl_acc_ap_sequencer: burst splitting, stalls, write
// drain accounting, ap_ctrl_chain handshakes and asynchronous reset.
module tb_krnl_acc_ap_sequencer;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         ap_start = 1'b0, ap_continue = 1'b0;
  logic         ap_ready, ap_done, ap_idle;
  logic [63:0]  src_addr = '0, dest_addr = '0;
  logic [31:0]  words_num = '0;
  logic         mode = 1'b0, cbc_mode = 1'b0;
  logic [31:0]  iv_w3 = 32'hDEAD_0003, iv_w2 = 32'hBEEF_0002;
  logic [31:0]  iv_w1 = 32'hCAFE_0001, iv_w0 = 32'hF00D_0000;
  logic         core_start, core_mode, core_cbc_mode;
  logic [127:0] core_iv;
  logic         rd_cmd_valid, wr_cmd_valid;
  logic         rd_cmd_ready = 1'b1, wr_cmd_ready = 1'b1;
  logic [63:0]  rd_cmd_addr, wr_cmd_addr;
  logic [8:0]   rd_cmd_len, wr_cmd_len;
  logic         wr_burst_done = 1'b0;

  int nPass = 0;
  int nChecks = 0;
  int readyCount = 0;
  int rc0;

  krnl_acc_ap_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .src_addr(src_addr), .dest_addr(dest_addr), .words_num(words_num),
    .mode(mode), .cbc_mode(cbc_mode),
    .iv_w3(iv_w3), .iv_w2(iv_w2), .iv_w1(iv_w1), .iv_w0(iv_w0),
    .core_start(core_start), .core_mode(core_mode),
    .core_cbc_mode(core_cbc_mode), .core_iv(core_iv),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_burst_done(wr_burst_done)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (ap_ready === 1'b1) readyCount++;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [63:0] src, input logic [63:0] dst,
                               input logic [31:0] words, input logic m, input logic c);
    src_addr  = src;
    dest_addr = dst;
    words_num = words;
    mode      = m;
    cbc_mode  = c;
    ap_start  = 1'b1;
  endtask

  task automatic pulseDone(input int n);
    wr_burst_done = 1'b1;
    repeat (n) tick();
    wr_burst_done = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (ap_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, ap_done, 1);
  endtask

  task automatic continueJob();
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_done_ready", {ap_done, ap_ready, core_start}, 0);
    checkOutput("rst_valids", {rd_cmd_valid, wr_cmd_valid}, 0);
    checkOutput("rst_iv", core_iv, 0);
    ARESET = 1'b0;
    tick();

    // 130 words: 64 + 64 + 2 on both channels
    applyStimulus(64'h1000_0000, 64'h2000_0000, 130, 1'b1, 1'b0);
    tick();
    checkOutput("t1_ready", {ap_ready, core_start, ap_idle}, 3'b110);
    checkOutput("t1_mode", {core_mode, core_cbc_mode}, 2'b10);
    checkOutput("t1_iv", core_iv, 128'hDEAD0003_BEEF0002_CAFE0001_F00D0000);
    checkOutput("t1_rd_not_yet", rd_cmd_valid, 0);
    ap_start = 1'b0;
    tick();
    checkOutput("t1_ready_drop", ap_ready, 0);
    checkOutput("t1_rd0", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h1000_0000, 9'd64});
    checkOutput("t1_wr0", {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, {1'b1, 64'h2000_0000, 9'd64});
    tick();
    checkOutput("t1_rd1", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h1000_0400, 9'd64});
    checkOutput("t1_wr1", {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, {1'b1, 64'h2000_0400, 9'd64});
    tick();
    checkOutput("t1_rd2", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h1000_0800, 9'd2});
    checkOutput("t1_wr2", {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, {1'b1, 64'h2000_0800, 9'd2});
    tick();
    checkOutput("t1_cmds_end", {rd_cmd_valid, wr_cmd_valid}, 0);
    pulseDone(2);
    tick();
    tick();
    checkOutput("t1_not_done_2of3", ap_done, 0);
    pulseDone(1);
    waitDone("t1_done", 4);
    tick();
    tick();
    checkOutput("t1_done_held", ap_done, 1);
    continueJob();
    checkOutput("t1_after_continue", {ap_done, ap_idle}, 2'b01);

    // Zero-length job
    applyStimulus(64'h4000_0000, 64'h5000_0000, 0, 1'b0, 1'b1);
    tick();
    checkOutput("t2_ready_done", {ap_ready, ap_done}, 2'b11);
    ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_no_cmds", {rd_cmd_valid, wr_cmd_valid}, 0);
      tick();
    end
    checkOutput("t2_cbc", {core_mode, core_cbc_mode}, 2'b01);
    continueJob();
    checkOutput("t2_idle", ap_idle, 1);

    // Read channel stalled for 5 cycles
    rd_cmd_ready = 1'b0;
    applyStimulus(64'h3000_0000, 64'h6000_0000, 66, 1'b0, 1'b0);
    tick();
    ap_start = 1'b0;
    tick();
    checkOutput("t3_rd_first", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h3000_0000, 9'd64});
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_rd_stable", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h3000_0000, 9'd64});
    end
    checkOutput("t3_wr_finished", wr_cmd_valid, 0);
    rd_cmd_ready = 1'b1;
    tick();
    checkOutput("t3_rd_one_hs", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, {1'b1, 64'h3000_0400, 9'd2});
    tick();
    checkOutput("t3_rd_end", rd_cmd_valid, 0);
    pulseDone(1);
    tick();
    checkOutput("t3_not_done", ap_done, 0);
    pulseDone(1);
    waitDone("t3_done", 4);
    continueJob();

    // Burst completion coincident with the second write handshake
    applyStimulus(64'h7000_0000, 64'h8000_0000, 130, 1'b0, 1'b0);
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    wr_burst_done = 1'b1;
    tick();
    wr_burst_done = 1'b0;
    tick();
    checkOutput("t4_wr_end", wr_cmd_valid, 0);
    tick();
    tick();
    pulseDone(1);
    tick();
    tick();
    checkOutput("t4_not_done_coinc", ap_done, 0);
    pulseDone(1);
    waitDone("t4_done", 4);
    continueJob();

    // Stray completion while idle must not disturb the next job
    pulseDone(2);
    checkOutput("t4_stray_idle", {ap_idle, ap_done}, 2'b10);
    applyStimulus(64'h9000_0000, 64'hA000_0000, 1, 1'b0, 1'b0);
    tick();
    ap_start = 1'b0;
    tick();
    checkOutput("t4_single", {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, {1'b1, 64'hA000_0000, 9'd1});
    tick();
    tick();
    tick();
    checkOutput("t4_single_wait", ap_done, 0);
    pulseDone(1);
    waitDone("t4_single_done", 4);
    continueJob();

    // ap_start held across a whole job
    rc0 = readyCount;
    applyStimulus(64'hB000_0000, 64'hC000_0000, 1, 1'b0, 1'b0);
    tick();
    checkOutput("t5_ready1", ap_ready, 1);
    tick();
    checkOutput("t5_ready1_drop", ap_ready, 0);
    tick();
    tick();
    pulseDone(1);
    waitDone("t5_done1", 4);
    tick();
    tick();
    checkOutput("t5_one_ready", readyCount - rc0, 1);
    continueJob();
    checkOutput("t5_back_idle", {ap_idle, ap_ready, ap_done}, 3'b100);
    tick();
    checkOutput("t5_ready2", {ap_ready, ap_idle}, 2'b10);
    ap_start = 1'b0;
    tick();
    tick();
    tick();
    pulseDone(1);
    waitDone("t5_done2", 4);
    continueJob();
    checkOutput("t5_two_readys", readyCount - rc0, 2);

    // Asynchronous reset in the middle of ISSUE
    rd_cmd_ready = 1'b0;
    applyStimulus(64'hD000_0000, 64'hE000_0000, 130, 1'b1, 1'b1);
    tick();
    ap_start = 1'b0;
    tick();
    checkOutput("t6_pre_rst", {rd_cmd_valid, wr_cmd_valid}, 2'b11);
    #3;
    ARESET = 1'b1;
    #1;
    checkOutput("t6_rst_ctrl", {ap_idle, ap_done, ap_ready, core_start}, 4'b1000);
    checkOutput("t6_rst_rd", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len}, 0);
    checkOutput("t6_rst_wr", {wr_cmd_valid, wr_cmd_addr, wr_cmd_len}, 0);
    checkOutput("t6_rst_core", {core_mode, core_cbc_mode, core_iv}, 0);
    #2;
    ARESET = 1'b0;
    rd_cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t6_post_rst", {ap_idle, ap_done, rd_cmd_valid, wr_cmd_valid}, 4'b1000);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
